// File: rtl/sum_latch_pkg.sv
// Shared types and constants for the sum/latch/UART block family.
package sum_latch_pkg;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Ceiling log2; clog2(1) = 0 so a single-value counter collapses cleanly
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serialiser; a start in the final stop-bit cycle chains
// the next frame with no idle gap.
module uart_tx_byte
  import sum_latch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int FRAME_DATA_BITS = UART_FRAME_BITS - 2;

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             txd_nxt;
  logic             bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign busy    = (state != IDLE);
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      txd     <= txd_nxt;
    end
  end

  // txd is registered so the line changes exactly on bit boundaries
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    txd_nxt     = txd;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (start) begin
          state_nxt = START;
          shreg_nxt = data;
          txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          txd_nxt     = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg >> 1;
            txd_nxt     = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_nxt = START;
            shreg_nxt = data;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/sum_latch_uart_nch.sv
// Latches NUM_OPS operands from a shared bus, registers their sum and sends
// it LSB-byte-first as back-to-back 8N1 frames.
module sum_latch_uart_nch
  import sum_latch_pkg::*;
#(
  parameter int DATA_W       = 5,
  parameter int NUM_OPS      = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int AUTO_SEND    = 1,
  localparam int SUM_W       = DATA_W + clog2(NUM_OPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_OPS-1:0] save_n,
  input  logic [DATA_W-1:0]  data_input,
  input  logic               send_n,
  input  logic               uart_tx_en,
  output logic               uart_txd,
  output logic               uart_tx_busy,
  output logic [NUM_OPS-1:0] valid_mask,
  output logic [SUM_W-1:0]   sum_out
);

  localparam int NBYTES = (SUM_W + 7) / 8;
  localparam int PAD_W  = 8 * NBYTES;
  localparam int CNT_W  = clog2(NBYTES + 1);

  logic [NUM_OPS-1:0] save_s1, save_s2, save_s3, save_pulse;
  logic               send_s1, send_s2, send_s3, send_pulse;
  logic [DATA_W-1:0]  op [NUM_OPS];
  logic [SUM_W-1:0]   sum_comb;
  logic               all_valid_d, auto_trig, accept;
  logic [PAD_W-1:0]   sum_pad, tx_shift;
  logic [CNT_W-1:0]   byte_cnt;
  logic               tx_start, tx_done, next_byte;
  logic [7:0]         tx_data;

  // Stages reset high (strobe idle level) so no false edge follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      save_s1 <= '1;
      save_s2 <= '1;
      save_s3 <= '1;
      send_s1 <= 1'b1;
      send_s2 <= 1'b1;
      send_s3 <= 1'b1;
    end else begin
      save_s1 <= save_n;
      save_s2 <= save_s1;
      save_s3 <= save_s2;
      send_s1 <= send_n;
      send_s2 <= send_s1;
      send_s3 <= send_s2;
    end
  end

  assign save_pulse = save_s3 & ~save_s2;
  assign send_pulse = send_s3 & ~send_s2;

  // A save in the accept cycle wins over the clear for its own channel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
      valid_mask <= '0;
    end else begin
      if (accept) valid_mask <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        if (save_pulse[i]) begin
          op[i]         <= data_input;
          valid_mask[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < NUM_OPS; i++) sum_comb = sum_comb + SUM_W'(op[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_out     <= '0;
      all_valid_d <= 1'b0;
    end else begin
      sum_out     <= sum_comb;
      all_valid_d <= &valid_mask;
    end
  end

  // Waiting one full all-valid cycle lets sum_out absorb the final save
  assign auto_trig = (AUTO_SEND != 0) && all_valid_d && (&valid_mask);
  assign accept    = (send_pulse || auto_trig) && !uart_tx_busy && uart_tx_en;
  assign sum_pad   = PAD_W'(sum_out);
  assign next_byte = tx_done && (byte_cnt > CNT_W'(1));
  assign tx_start  = accept || next_byte;
  assign tx_data   = accept ? sum_pad[7:0] : tx_shift[7:0];

  // Byte 0 goes straight to the serialiser; tx_shift holds the rest
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      tx_shift <= sum_pad >> 8;
      byte_cnt <= CNT_W'(NBYTES);
    end else if (tx_done) begin
      byte_cnt <= byte_cnt - 1'b1;
      if (next_byte) tx_shift <= tx_shift >> 8;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .start(tx_start),
    .data (tx_data),
    .txd  (uart_txd),
    .busy (uart_tx_busy),
    .done (tx_done)
  );

endmodule

// File: tb/tb_sum_latch_uart_nch.sv
// Bench for sum_latch_uart_nch: three configurations share one clock/reset;
// a byte queue holds expected frames and a line decoder pops and compares.
module tb_sum_latch_uart_nch;

  localparam int CPB = 4;

  typedef struct {
    logic [1:0] mask;
    logic [4:0] data;
    logic [5:0] exp_sum;
    logic [1:0] exp_vm;
  } vec_t;

  logic       clk, reset;
  logic [1:0] save_a, save_c;
  logic [3:0] save_b;
  logic [4:0] data_a, data_c;
  logic [7:0] data_b;
  logic [2:0] send_v, en_v, txd_v, busy_v;
  logic [1:0] vm_a, vm_c;
  logic [3:0] vm_b;
  logic [5:0] sum_a, sum_c;
  logic [9:0] sum_b;
  logic [7:0] exp_q[$];
  vec_t       vecs[6];
  int         checks = 0;
  int         failures = 0;

  sum_latch_uart_nch #(.DATA_W(5), .NUM_OPS(2), .CLKS_PER_BIT(CPB), .AUTO_SEND(1)) dut_a (
    .clk(clk), .reset(reset), .save_n(save_a), .data_input(data_a), .send_n(send_v[0]),
    .uart_tx_en(en_v[0]), .uart_txd(txd_v[0]), .uart_tx_busy(busy_v[0]),
    .valid_mask(vm_a), .sum_out(sum_a));

  sum_latch_uart_nch #(.DATA_W(8), .NUM_OPS(4), .CLKS_PER_BIT(CPB), .AUTO_SEND(1)) dut_b (
    .clk(clk), .reset(reset), .save_n(save_b), .data_input(data_b), .send_n(send_v[1]),
    .uart_tx_en(en_v[1]), .uart_txd(txd_v[1]), .uart_tx_busy(busy_v[1]),
    .valid_mask(vm_b), .sum_out(sum_b));

  sum_latch_uart_nch #(.DATA_W(5), .NUM_OPS(2), .CLKS_PER_BIT(CPB), .AUTO_SEND(0)) dut_c (
    .clk(clk), .reset(reset), .save_n(save_c), .data_input(data_c), .send_n(send_v[2]),
    .uart_tx_en(en_v[2]), .uart_txd(txd_v[2]), .uart_tx_busy(busy_v[2]),
    .valid_mask(vm_c), .sum_out(sum_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic driveSave(input int d, input logic [3:0] mask, input logic [7:0] data);
    case (d)
      0:       begin data_a = data[4:0]; save_a = ~mask[1:0]; end
      1:       begin data_b = data;      save_b = ~mask;      end
      default: begin data_c = data[4:0]; save_c = ~mask[1:0]; end
    endcase
  endtask

  // Returns on the negedge right after the latching edge
  task automatic saveOp(input int d, input logic [3:0] mask, input logic [7:0] data);
    @(negedge clk);
    driveSave(d, mask, data);
    repeat (3) @(negedge clk);
    driveSave(d, 4'b0000, data);
  endtask

  task automatic sendPulse(input int d);
    @(negedge clk);
    send_v[d] = 1'b0;
    repeat (2) @(negedge clk);
    send_v[d] = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    saveOp(2, {2'b00, v.mask}, {3'b000, v.data});
  endtask

  task automatic recvFrames(input int d, input int n, input int exp_wait, input string tag);
    int         waited, cnt, idx;
    logic       s[$];
    logic       got;
    logic [9:0] fr;
    logic [7:0] exp_b;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 64) begin
      @(negedge clk);
      waited++;
      got = busy_v[d];
    end
    checkOutput({tag, "_busy_rise"}, 32'(got), 1);
    checkOutput({tag, "_latency"}, waited, exp_wait);
    cnt = 0;
    while (busy_v[d] && cnt < 400) begin
      s.push_back(txd_v[d]);
      cnt++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_len"}, cnt, 10 * n * CPB);
    checkOutput({tag, "_idle_txd"}, 32'(txd_v[d]), 1);
    for (int f = 0; f < n; f++) begin
      exp_b = 8'h00;
      if (exp_q.size() > 0) exp_b = exp_q.pop_front();
      for (int j = 0; j < 10; j++) begin
        idx = (f * 10 + j) * CPB + CPB / 2;
        fr[j] = (idx < s.size()) ? s[idx] : 1'bx;
      end
      checkOutput({tag, "_frame"}, 32'(fr), {22'd0, 1'b1, exp_b, 1'b0});
    end
  endtask

  task automatic watchIdle(input int d, input int cycles, input string tag);
    int busy_seen, low_seen;
    busy_seen = 0;
    low_seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy_v[d]) busy_seen++;
      if (!txd_v[d]) low_seen++;
    end
    checkOutput({tag, "_busy"}, busy_seen, 0);
    checkOutput({tag, "_txd_low"}, low_seen, 0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{2'b01, 5'd3, 6'd3,  2'b01};
    vecs[1] = '{2'b10, 5'd4, 6'd7,  2'b11};
    vecs[2] = '{2'b11, 5'd7, 6'd14, 2'b11};
    vecs[3] = '{2'b01, 5'd3, 6'd10, 2'b11};
    vecs[4] = '{2'b10, 5'd4, 6'd7,  2'b11};
    vecs[5] = '{2'b01, 5'd9, 6'd13, 2'b11};

    reset = 1'b1;
    save_a = '1; save_b = '1; save_c = '1;
    data_a = '0; data_b = '0; data_c = '0;
    send_v = '1; en_v = '1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", 32'(txd_v), 32'h7);
    checkOutput("reset_busy", 32'(busy_v), 0);
    checkOutput("reset_vm", {vm_a, vm_b, vm_c}, 0);
    checkOutput("reset_sum", {sum_a, sum_b, sum_c}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] auto-send, defaults");
    @(negedge clk);
    driveSave(0, 4'b0001, 8'h1F);
    repeat (2) @(negedge clk);
    checkOutput("save_lat_early", 32'(vm_a), 0);
    @(negedge clk);
    checkOutput("save_lat_vm", 32'(vm_a), 1);
    checkOutput("save_lat_sum_early", 32'(sum_a), 0);
    driveSave(0, 4'b0000, 8'h1F);
    @(negedge clk);
    checkOutput("save_lat_sum", 32'(sum_a), 32'h1F);
    exp_q.push_back(8'h3E);
    saveOp(0, 4'b0010, 8'h1F);
    recvFrames(0, 1, 2, "auto_a");
    checkOutput("auto_a_sum", 32'(sum_a), 32'h3E);
    checkOutput("auto_a_vm", 32'(vm_a), 0);

    $display("[TB] auto-send, 8-bit x4");
    exp_q.push_back(8'hFC);
    exp_q.push_back(8'h03);
    saveOp(1, 4'b1111, 8'hFF);
    recvFrames(1, 2, 2, "auto_b");
    checkOutput("auto_b_sum", 32'(sum_b), 32'h3FC);
    checkOutput("auto_b_vm", 32'(vm_b), 0);

    $display("[TB] manual-send table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_vm", i), 32'(vm_c), 32'(vecs[i].exp_vm));
      checkOutput($sformatf("vec%0d_sum", i), 32'(sum_c), 32'(vecs[i].exp_sum));
    end
    watchIdle(2, 10, "no_auto");
    exp_q.push_back(8'h0D);
    sendPulse(2);
    recvFrames(2, 1, 1, "send_c");
    checkOutput("send_c_vm", 32'(vm_c), 0);

    $display("[TB] send and save during busy");
    exp_q.push_back(8'h0D);
    sendPulse(2);
    fork
      recvFrames(2, 1, 1, "inflight");
      begin
        repeat (6) @(negedge clk);
        sendPulse(2);
        saveOp(2, 4'b0001, 8'h01);
      end
    join
    checkOutput("inflight_vm", 32'(vm_c), 1);
    checkOutput("inflight_sum", 32'(sum_c), 5);
    watchIdle(2, 30, "busy_drop");

    $display("[TB] send with tx disabled");
    en_v[2] = 1'b0;
    sendPulse(2);
    watchIdle(2, 20, "en_drop");
    checkOutput("en_drop_vm", 32'(vm_c), 1);
    en_v[2] = 1'b1;

    $display("[TB] reset mid-frame");
    sendPulse(2);
    waited = 0;
    while (!busy_v[2] && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pre_reset_busy", 32'(busy_v[2]), 1);
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_txd", 32'(txd_v[2]), 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_txd", 32'(txd_v[2]), 1);
    checkOutput("mid_reset_busy", 32'(busy_v[2]), 0);
    checkOutput("mid_reset_sum", 32'(sum_c), 0);
    checkOutput("mid_reset_vm", 32'(vm_c), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h00);
    sendPulse(2);
    recvFrames(2, 1, 1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_latch_uart_nch.md
# sum_latch_uart_nch

Parametrised successor to the two-operand sum/latch/UART block. Latches `NUM_OPS` operands of `DATA_W` bits from a shared data bus using per-channel active-low save strobes. Forms their registered sum and transmits it LSB-byte-first as 8N1 UART frames, either on an explicit send strobe or automatically once every channel holds a value. Sits directly under the Tiny Tapeout wrapper, driving the UART pins.

## Interface
Parameters:
- `DATA_W`, 5, operand width (1..16).
- `NUM_OPS`, 2, operand channel count (2..8).
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (≥2).
- `AUTO_SEND`, 1, 1 = transmit automatically when all channels are valid.

Derived:
- `SUM_W` = `DATA_W + clog2(NUM_OPS)`.
- `NBYTES` = ceil(`SUM_W`/8).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `save_n`  in  NUM_OPS  active-low per-channel latch strobes, asynchronous to `clk`.
- `data_input`  in  DATA_W  shared operand bus.
- `send_n`  in  1  active-low transmit request, asynchronous to `clk`.
- `uart_tx_en`  in  1  transmit enable; gates trigger acceptance only.
- `uart_txd`  out  1  UART serial line, idle high.
- `uart_tx_busy`  out  1  high while frames are in flight.
- `valid_mask`  out  NUM_OPS  bit i set when channel i has latched a value since the last send.
- `sum_out`  out  SUM_W  registered sum of all operand registers.

## Operation
- `save_n[i]` and `send_n` each pass through a 2-FF synchroniser followed by a falling-edge detector.
- Channel latch: on a `save_n[i]` edge pulse, `op[i]` ← `data_input` and `valid_mask[i]` ← 1.
  - Simultaneous edges on several channels latch the same value into each of them.
  - A re-save overwrites the channel.
- Sum: `sum_out` ← zero-extended sum of all `op[i]` every cycle, one register stage. No overflow is possible at `SUM_W`.
- Trigger sources:
  - `send_n` edge pulse.
  - With `AUTO_SEND`=1: `valid_mask` has been all-ones for one full cycle. This guarantees `sum_out` reflects the last save.
- A trigger is accepted only when `uart_tx_busy`=0 and `uart_tx_en`=1. Otherwise it is dropped, not queued.
- On acceptance:
  - Snapshot `sum_out` into a tx shift register, zero-padded to 8·`NBYTES`.
  - Clear `valid_mask`.
  - Load the byte counter with `NBYTES`.
- Saves during transmission update `op`/`valid_mask` and do not alter the snapshot.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on accept.
  - START→DATA after 1 bit time.
  - DATA→STOP after 8 bits, LSB first.
  - STOP→START (next byte) if bytes remain, else STOP→IDLE.
- Deasserting `uart_tx_en` mid-transfer has no effect; all `NBYTES` frames complete.
- Reset applies at any time, including mid-frame, and forces every register to its reset value on the next edge.

## Timing
- Reset values:
  - `uart_txd`=1.
  - `uart_tx_busy`=0.
  - `valid_mask`=0.
  - `sum_out`=0.
  - All `op`=0.
  - FSM in IDLE.
  - Synchroniser stages = 1, so no false edge is seen after reset.
- Save latency:
  - `op[i]`/`valid_mask[i]` update on the 3rd rising edge after `save_n[i]` is first sampled low.
  - `data_input` must be stable from the strobe's falling edge through that edge.
  - `sum_out` updates 1 cycle later.
- Send latency: `send_n` falling → accept on the 3rd edge.
- Accept cycle +1: `uart_tx_busy`=1 and `uart_txd`=0 (start bit).
- Each bit is held exactly `CLKS_PER_BIT` cycles. Bytes are back-to-back with no idle gap.
- `uart_tx_busy` is high for exactly 10·`NBYTES`·`CLKS_PER_BIT` cycles, then falls with `uart_txd`=1.
- A trigger in the first cycle `uart_tx_busy`=0 is accepted.
- Auto-send: accept occurs 2 cycles after the last `valid_mask` bit sets.

## Structure
- Package `sum_latch_pkg`:
  - `clog2` function.
  - `tx_state_t` enum (IDLE/START/DATA/STOP).
  - `UART_FRAME_BITS`=10 and `UART_DATA_BITS`=8 constants.
- Sub-module `uart_tx_byte`:
  - One 8N1 frame serialiser with `start`/`busy`/`done` handshake.
  - Parameterised by `CLKS_PER_BIT`.
  - The top block sequences `NBYTES` starts, one per `done`.
- Top block holds the synchronisers, edge detectors, operand registers, adder and snapshot/byte sequencer.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Defaults, `AUTO_SEND`=1, save ch0=0x1F then ch1=0x1F → `sum_out`=0x3E; one frame with `uart_txd` bits 0,0,1,1,1,1,1,0,0,1; busy high 40 cycles; `valid_mask`=00 after accept.
- `DATA_W`=8, `NUM_OPS`=4, all channels 0xFF → `sum_out`=0x3FC; frames 0xFC then 0x03 back-to-back; busy 80 cycles.
- `AUTO_SEND`=0, save ch0=3 and ch1=4 in the same cycle, then save ch0=9; pulse `send_n` → ch0=9, ch1=4, frame byte 0x0D.
- Pulse `send_n` during busy, and separately with `uart_tx_en`=0 → no new frame, `uart_txd` stays 1 afterward, `valid_mask` unchanged.
- Assert `reset` mid DATA bit → next cycle `uart_txd`=1, busy=0, `sum_out`=0, `valid_mask`=0; a subsequent send transmits 0x00.
- Save ch0 during transmission → in-flight bytes carry the old snapshot; `valid_mask[0]`=1 afterward.
